// File: rtl/rect_rasterizer.sv
// ---------------------------------------------------------------------------
// rect_rasterizer
//
// Flat-fill rectangle rasterizer feeding the rast->fbw FIFO in front of the
// framebuffer writer. One rectangle command is accepted at a time. It is
// clipped to the visible screen and then emitted as one pixel word per cycle
// in row-major order. The FIFO can apply backpressure at any cycle.
//
// Ports
//   PLB_clk     : sole clock, rising edge
//   reset       : synchronous, active-low (0 = reset)
//   cmd_valid   : a rectangle command is present
//   cmd_ready   : block is idle and can take a command
//   cmd_x0/x1   : left/right column, inclusive
//   cmd_y0/y1   : top/bottom line, inclusive
//   cmd_color   : fill colour
//   fifo_data   : pixel word {line(16, zero-padded), col(16, zero-padded), color(32)}
//   fifo_wr_en  : FIFO write strobe
//   fifo_full   : FIFO cannot take a write this cycle
//   busy        : high whenever not idle
//   pix_count   : pixels written since reset, wraps modulo 2^32
//
// The external buses keep the legacy ascending [0:N-1] numbering, so bit 0
// is the MSB. Internally everything is held in descending vectors; the
// numeric values are identical.
// ---------------------------------------------------------------------------
module rect_rasterizer #(
    parameter int LINE_LEN          = 9,
    parameter int COL_LEN           = 10,
    parameter int RAST_FBW_FIFO_LEN = 64,
    parameter int SCREEN_W          = 640,
    parameter int SCREEN_H          = 480
) (
    input  logic                           PLB_clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [0:COL_LEN-1]             cmd_x0,
    input  logic [0:COL_LEN-1]             cmd_x1,
    input  logic [0:LINE_LEN-1]            cmd_y0,
    input  logic [0:LINE_LEN-1]            cmd_y1,
    input  logic [0:31]                    cmd_color,
    output logic [0:RAST_FBW_FIFO_LEN-1]   fifo_data,
    output logic                           fifo_wr_en,
    input  logic                           fifo_full,
    output logic                           busy,
    output logic [0:31]                    pix_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLIP = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    localparam logic [COL_LEN-1:0]  X_MAX = COL_LEN'(SCREEN_W - 1);
    localparam logic [LINE_LEN-1:0] Y_MAX = LINE_LEN'(SCREEN_H - 1);

    logic [1:0]          state_q, state_d;
    logic [COL_LEN-1:0]  x0_q, x0_d;
    logic [COL_LEN-1:0]  x1_q, x1_d;      // holds x1c once CLIP has run
    logic [LINE_LEN-1:0] y0_q, y0_d;
    logic [LINE_LEN-1:0] y1_q, y1_d;      // holds y1c once CLIP has run
    logic [31:0]         color_q, color_d;
    logic [COL_LEN-1:0]  cur_x_q, cur_x_d;
    logic [LINE_LEN-1:0] cur_y_q, cur_y_d;
    logic [31:0]         pix_count_q, pix_count_d;

    logic [COL_LEN-1:0]  x1c;
    logic [LINE_LEN-1:0] y1c;
    logic                wr_en;

    // Clipped right/bottom edges; only meaningful while in CLIP.
    assign x1c = (x1_q > X_MAX) ? X_MAX : x1_q;
    assign y1c = (y1_q > Y_MAX) ? Y_MAX : y1_q;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign wr_en      = (state_q == ST_EMIT) && !fifo_full;
    assign fifo_wr_en = wr_en;
    assign fifo_data  = {16'(cur_y_q), 16'(cur_x_q), color_q};
    assign pix_count  = pix_count_q;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves a
        // variable unassigned and no latch can be inferred.
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        color_d     = color_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        pix_count_d = pix_count_q + (wr_en ? 32'd1 : 32'd0);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    x1_d    = cmd_x1;
                    y0_d    = cmd_y0;
                    y1_d    = cmd_y1;
                    color_d = cmd_color;
                    state_d = ST_CLIP;
                end
            end
            ST_CLIP: begin
                x1_d = x1c;
                y1_d = y1c;
                // One test catches x0 off-screen as well as swapped corners.
                if ((x0_q > x1c) || (y0_q > y1c)) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_x_d = x0_q;
                    cur_y_d = y0_q;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // A stalled cycle leaves position and state untouched, so the
                // current pixel is re-presented until the FIFO takes it.
                if (wr_en) begin
                    if (cur_x_q != x1_q) begin
                        cur_x_d = cur_x_q + COL_LEN'(1);
                    end else if (cur_y_q != y1_q) begin
                        cur_x_d = x0_q;
                        cur_y_d = cur_y_q + LINE_LEN'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PLB_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q     <= ST_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            pix_count_q <= pix_count_d;
        end
    end

endmodule

// File: tb/tb_rect_rasterizer.sv
// ---------------------------------------------------------------------------
// tb_rect_rasterizer
//
// Scoreboard bench for rect_rasterizer. Each command pushes its clipped
// pixel words onto a queue; a negedge monitor pops and compares every FIFO
// write. Directed checks cover reset state, latency, empty rectangles,
// backpressure, mid-frame reset and back-to-back commands.
// ---------------------------------------------------------------------------
module tb_rect_rasterizer;

    localparam int SW = 640;
    localparam int SH = 480;

    logic          PLB_clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [0:9]    cmd_x0, cmd_x1;
    logic [0:8]    cmd_y0, cmd_y1;
    logic [0:31]   cmd_color;
    logic [0:63]   fifo_data;
    logic          fifo_wr_en;
    logic          fifo_full;
    logic          busy;
    logic [0:31]   pix_count;

    logic [63:0]   exp_q[$];
    logic [63:0]   exp_word;
    logic [31:0]   exp_pix;
    int            n_vec;
    int            n_err;
    bit            tog_en;
    logic [5:0]    full_pat;

    always #5 PLB_clk = ~PLB_clk;

    rect_rasterizer dut (
        .PLB_clk    (PLB_clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_x1     (cmd_x1),
        .cmd_y0     (cmd_y0),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .fifo_data  (fifo_data),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: clip and enumerate pixels in row-major order.
    task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                             input logic [31:0] c);
        int x1c = (x1 > SW - 1) ? SW - 1 : x1;
        int y1c = (y1 > SH - 1) ? SH - 1 : y1;
        if (x0 <= x1c && y0 <= y1c) begin
            for (int y = y0; y <= y1c; y++) begin
                for (int x = x0; x <= x1c; x++) begin
                    exp_q.push_back({16'(y), 16'(x), c});
                    exp_pix++;
                end
            end
        end
    endtask

    // Drives a command at a negedge once the DUT is ready; returns just
    // after the accepting edge with cmd_valid dropped.
    task automatic send_cmd(input int x0, input int x1, input int y0, input int y1,
                            input logic [31:0] c);
        int k = 0;
        @(negedge PLB_clk);
        while (!cmd_ready && k < 300) begin
            @(negedge PLB_clk);
            k++;
        end
        check("ready_timeout", 64'(k < 300), 64'd1);
        cmd_x0    = 10'(x0);
        cmd_x1    = 10'(x1);
        cmd_y0    = 9'(y0);
        cmd_y1    = 9'(y1);
        cmd_color = c;
        cmd_valid = 1'b1;
        push_rect(x0, x1, y0, y1, c);
        @(posedge PLB_clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            @(negedge PLB_clk);
            k++;
        end while (!(cmd_ready && exp_q.size() == 0) && k < 500);
        check({tag, "_done_timeout"}, 64'(k < 500), 64'd1);
        check({tag, "_pix_count"}, 64'(pix_count), 64'(exp_pix));
    endtask

    // FIFO monitor: every write must be expected, in order, and never while full.
    always @(negedge PLB_clk) begin
        if (fifo_full)
            check("wr_while_full", 64'(fifo_wr_en), 64'd0);
        if (fifo_wr_en) begin
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                check("pixel", 64'(fifo_data), exp_word);
            end
        end
    end

    // Backpressure pattern 1,0,0,1,1,0 repeating, applied just after each edge.
    initial begin
        int idx = 0;
        fifo_full = 1'b0;
        full_pat  = 6'b011001;   // full_pat[idx] gives 1,0,0,1,1,0
        forever begin
            @(posedge PLB_clk);
            #1;
            if (tog_en) begin
                fifo_full = full_pat[idx];
                idx = (idx + 1) % 6;
            end else begin
                fifo_full = 1'b0;
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; exp_pix = '0; tog_en = 1'b0;
        reset = 1'b0; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;

        // Reset state
        repeat (2) @(posedge PLB_clk);
        @(negedge PLB_clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_pix_count", 64'(pix_count), 64'd0);
        reset = 1'b1;

        // 1) 4x2 rectangle, exact latency: CLIP cycle, 8 consecutive writes, then ready
        send_cmd(0, 3, 0, 1, 32'hDEADBEEF);
        @(negedge PLB_clk);
        check("t1_clip_busy", 64'(busy), 64'd1);
        check("t1_clip_no_wr", 64'(fifo_wr_en), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge PLB_clk);
            check("t1_consecutive_wr", 64'(fifo_wr_en), 64'd1);
        end
        @(negedge PLB_clk);
        check("t1_ready_after", 64'(cmd_ready), 64'd1);
        check("t1_pix_count", 64'(pix_count), 64'd8);

        // 2) Clipped against right and bottom edges
        send_cmd(636, 700, 479, 500, 32'h12345678);
        wait_idle("t2");

        // 3) Empty rectangles: off-screen x0, then swapped corners
        send_cmd(640, 700, 0, 0, 32'hAAAA5555);
        @(negedge PLB_clk);
        check("t3a_clip_busy", 64'(busy), 64'd1);
        @(negedge PLB_clk);
        check("t3a_ready", 64'(cmd_ready), 64'd1);
        send_cmd(5, 2, 3, 3, 32'h5555AAAA);
        @(negedge PLB_clk);
        check("t3b_clip_busy", 64'(busy), 64'd1);
        @(negedge PLB_clk);
        check("t3b_ready", 64'(cmd_ready), 64'd1);
        check("t3_pix_count", 64'(pix_count), 64'(exp_pix));

        // 4) 3x3 with FIFO backpressure
        tog_en = 1'b1;
        send_cmd(10, 12, 20, 22, 32'h0BADF00D);
        wait_idle("t4");
        tog_en = 1'b0;

        // 5) Reset mid-EMIT of a 10x10 rectangle
        send_cmd(0, 9, 0, 9, 32'hCAFEF00D);
        repeat (21) @(negedge PLB_clk);
        reset = 1'b0;
        @(posedge PLB_clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_pix = '0;
        @(negedge PLB_clk);
        check("t5_no_wr", 64'(fifo_wr_en), 64'd0);
        check("t5_ready", 64'(cmd_ready), 64'd1);
        check("t5_pix_count", 64'(pix_count), 64'd0);
        send_cmd(2, 4, 5, 6, 32'h01020304);
        wait_idle("t5_next");

        // 6) Back-to-back 1x2 commands with cmd_valid held high
        @(negedge PLB_clk);
        cmd_x0 = 10'd100; cmd_x1 = 10'd101; cmd_y0 = 9'd7; cmd_y1 = 9'd7;
        cmd_color = 32'h11111111;
        cmd_valid = 1'b1;
        push_rect(100, 101, 7, 7, 32'h11111111);
        @(posedge PLB_clk);
        #1;
        cmd_x0 = 10'd200; cmd_x1 = 10'd201; cmd_y0 = 9'd8; cmd_y1 = 9'd8;
        cmd_color = 32'h22222222;
        push_rect(200, 201, 8, 8, 32'h22222222);
        for (int i = 0; i < 3; i++) begin
            @(negedge PLB_clk);
            check("t6_not_ready", 64'(cmd_ready), 64'd0);
        end
        @(negedge PLB_clk);
        check("t6_ready_first_idle", 64'(cmd_ready), 64'd1);
        @(posedge PLB_clk);
        #1 cmd_valid = 1'b0;
        @(negedge PLB_clk);
        check("t6_second_clip", 64'(busy), 64'd1);
        wait_idle("t6");
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
